// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// Divisor latched with LoadD, dividend latched when Run starts a division.
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Switches,
    input  logic             LoadD,
    input  logic             Run,
    output logic [WIDTH-1:0] Quotient_guts,
    output logic [WIDTH-1:0] Remainder_guts,
    output logic [WIDTH-1:0] Divisor_guts,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ITER,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dbz, dbz_n;

    logic [WIDTH:0]   r_sh;
    logic             fits;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            dbz   <= 1'b0;
        end else begin
            state <= state_n;
            quo   <= quo_n;
            rem   <= rem_n;
            dvs   <= dvs_n;
            cnt   <= cnt_n;
            dbz   <= dbz_n;
        end
    end

    // Shifted remainder keeps the extra msb so 2*rem+bit cannot overflow.
    always_comb begin
        r_sh    = {rem, quo[WIDTH-1]};
        fits    = (r_sh >= {1'b0, dvs});
        state_n = state;
        quo_n   = quo;
        rem_n   = rem;
        dvs_n   = dvs;
        cnt_n   = cnt;
        dbz_n   = dbz;
        unique case (state)
            IDLE: begin
                if (LoadD) begin
                    dvs_n = Switches;
                end else if (Run) begin
                    state_n = LOAD;
                end
            end
            LOAD: begin
                quo_n = Switches;
                rem_n = '0;
                cnt_n = '0;
                dbz_n = 1'b0;
                if (dvs == '0) begin
                    quo_n   = '1;
                    rem_n   = Switches;
                    dbz_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = ITER;
                end
            end
            ITER: begin
                if (fits) begin
                    rem_n = WIDTH'(r_sh - {1'b0, dvs});
                    quo_n = {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem_n = r_sh[WIDTH-1:0];
                    quo_n = {quo[WIDTH-2:0], 1'b0};
                end
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!Run) begin
                    state_n = IDLE;
                    dbz_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign Quotient_guts  = quo;
    assign Remainder_guts = rem;
    assign Divisor_guts   = dvs;
    assign Busy           = (state == LOAD) || (state == ITER);
    assign Done           = (state == DONE);
    assign DivByZero      = dbz;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider with immediate-assertion checks.
// Expected quotients/remainders are hand-computed constants.
module tb_restoring_divider;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] Switches;
    logic       LoadD;
    logic       Run;
    logic [7:0] Quotient_guts;
    logic [7:0] Remainder_guts;
    logic [7:0] Divisor_guts;
    logic       Busy;
    logic       Done;
    logic       DivByZero;

    int total = 0;
    int bad   = 0;

    restoring_divider #(.WIDTH(8)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Switches      (Switches),
        .LoadD         (LoadD),
        .Run           (Run),
        .Quotient_guts (Quotient_guts),
        .Remainder_guts(Remainder_guts),
        .Divisor_guts  (Divisor_guts),
        .Busy          (Busy),
        .Done          (Done),
        .DivByZero     (DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1ns later; also guard Busy/Done exclusivity.
    task automatic tick();
        @(posedge Clk);
        #1;
        chk("busy_done_excl", {31'd0, Busy & Done}, 32'd0);
    endtask

    task automatic load_d(input logic [7:0] v);
        Switches = v;
        LoadD    = 1'b1;
        tick();
        LoadD    = 1'b0;
        chk("divisor_load", {24'd0, Divisor_guts}, {24'd0, v});
    endtask

    // Start a division, count edges after E0 until Done and Busy cycles.
    task automatic do_div(input string tag, input logic [7:0] dividend,
                          input logic [7:0] exp_q, input logic [7:0] exp_r,
                          input int exp_edges);
        int n;
        int busy_cnt;
        Switches = dividend;
        Run      = 1'b1;
        tick();
        n        = 0;
        busy_cnt = 0;
        while (!Done && n < 40) begin
            if (Busy) busy_cnt++;
            tick();
            n++;
        end
        chk({tag, "_edges"}, n, exp_edges);
        chk({tag, "_busy"}, busy_cnt, 9);
        chk({tag, "_q"}, {24'd0, Quotient_guts}, {24'd0, exp_q});
        chk({tag, "_r"}, {24'd0, Remainder_guts}, {24'd0, exp_r});
        chk({tag, "_dbz"}, {31'd0, DivByZero}, 32'd0);
        Run = 1'b0;
        tick();
        chk({tag, "_idle"}, {31'd0, Done}, 32'd0);
    endtask

    initial begin
        Reset    = 1'b0;
        Switches = 8'h00;
        LoadD    = 1'b0;
        Run      = 1'b0;
        tick();
        tick();
        chk("rst_q", {24'd0, Quotient_guts}, 32'd0);
        chk("rst_r", {24'd0, Remainder_guts}, 32'd0);
        chk("rst_d", {24'd0, Divisor_guts}, 32'd0);
        chk("rst_flags", {29'd0, Busy, Done, DivByZero}, 32'd0);
        Reset = 1'b1;
        tick();

        load_d(8'h07);
        do_div("d100_7", 8'h64, 8'h0E, 8'h02, 9);
        load_d(8'h01);
        do_div("d255_1", 8'hFF, 8'hFF, 8'h00, 9);
        load_d(8'hFF);
        do_div("d255_255", 8'hFF, 8'h01, 8'h00, 9);
        load_d(8'h09);
        do_div("d5_9", 8'h05, 8'h00, 8'h05, 9);

        // Divide by zero: Done by E0+2 with saturated quotient.
        load_d(8'h00);
        Switches = 8'h2A;
        Run      = 1'b1;
        tick();
        chk("dz_busy_load", {31'd0, Busy}, 32'd1);
        tick();
        tick();
        chk("dz_done", {31'd0, Done}, 32'd1);
        chk("dz_flag", {31'd0, DivByZero}, 32'd1);
        chk("dz_q", {24'd0, Quotient_guts}, 32'h0FF);
        chk("dz_r", {24'd0, Remainder_guts}, 32'h02A);
        Run = 1'b0;
        tick();
        chk("dz_clear", {30'd0, Done, DivByZero}, 32'd0);

        // LoadD during ITER ignored; Run held 30 cycles gives a single division.
        load_d(8'h07);
        Switches = 8'h64;
        Run      = 1'b1;
        tick();
        tick();
        tick();
        Switches = 8'h33;
        LoadD    = 1'b1;
        tick();
        LoadD    = 1'b0;
        chk("iter_loadd", {24'd0, Divisor_guts}, 32'h07);
        for (int i = 0; i < 27; i++) tick();
        chk("hold_done", {31'd0, Done}, 32'd1);
        chk("hold_q", {24'd0, Quotient_guts}, 32'h0E);
        chk("hold_r", {24'd0, Remainder_guts}, 32'h02);
        chk("hold_divisor", {24'd0, Divisor_guts}, 32'h07);
        Run = 1'b0;
        tick();
        chk("hold_release", {31'd0, Done}, 32'd0);

        // Reset in the 4th ITER cycle aborts the division.
        Switches = 8'h64;
        Run      = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
        Reset = 1'b0;
        tick();
        chk("mid_rst_q", {24'd0, Quotient_guts}, 32'd0);
        chk("mid_rst_r", {24'd0, Remainder_guts}, 32'd0);
        chk("mid_rst_d", {24'd0, Divisor_guts}, 32'd0);
        chk("mid_rst_flags", {29'd0, Busy, Done, DivByZero}, 32'd0);
        Reset = 1'b1;
        Run   = 1'b0;
        tick();
        load_d(8'h07);
        do_div("fresh", 8'h64, 8'h0E, 8'h02, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
